// File: rtl/pin_lock_ctrl.sv
// PIN/PUK access controller: BCD digit entry, stored-PIN compare, PIN change,
// failure lockout with PUK unlock, and an automatic entry timeout.
//   state     | meaning
//   IDLE      | waiting for CLEAR
//   ENT_PIN   | timed PIN entry
//   ENT_OLD   | timed old-PIN entry before a change
//   ENT_NEW   | timed new-PIN entry
//   LOCKED    | locked out, waiting for CLEAR
//   ENT_PUK   | untimed PUK entry
module pin_lock_ctrl #(
    parameter int                   PIN_LEN     = 4,
    parameter int                   PUK_LEN     = 8,
    parameter int                   MAX_FAIL    = 3,
    parameter int                   TIMEOUT_CYC = 2000000000,
    parameter int                   BLINK_CYC   = 25000000,
    parameter logic [4*PIN_LEN-1:0] PIN_INIT    = '0,
    parameter logic [4*PUK_LEN-1:0] PUK_VALUE   = 32'h99999999
) (
    input  logic                           i_clock_50,
    input  logic                           i_reset,
    input  logic [3:0]                     i_digit,
    input  logic                           i_enter,
    input  logic                           i_clear,
    input  logic                           i_mode,
    output logic                           o_unlocked,
    output logic                           o_lockout,
    output logic [2:0]                     o_status,
    output logic [4*PUK_LEN-1:0]           o_entry,
    output logic [$clog2(PUK_LEN+1)-1:0]   o_count,
    output logic                           o_timer_led
);
    localparam int EW = 4*PUK_LEN;
    localparam int PW = 4*PIN_LEN;
    localparam int CW = $clog2(PUK_LEN+1);
    localparam int FW = $clog2(MAX_FAIL+1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int BW = $clog2(BLINK_CYC+1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC-1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_CYC-1);
    localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

    localparam logic [2:0] ST_NONE = 3'd0, ST_ON = 3'd1, ST_ERR = 3'd2, ST_TOUT = 3'd3,
                           ST_LOCK = 3'd4, ST_STORED = 3'd5, ST_OLD_OK = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_ENT_PIN, S_ENT_OLD, S_ENT_NEW, S_LOCKED, S_ENT_PUK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_pin, w_pin_nxt;
    logic [FW-1:0]   r_fail, w_fail_nxt, w_fail_inc;
    logic            r_unlocked, w_unlocked_nxt;
    logic            r_lockout, w_lockout_nxt;
    logic [2:0]      r_status, w_status_nxt;
    logic [EW-1:0]   r_entry, w_entry_nxt;
    logic [CW-1:0]   r_count, w_count_nxt, w_len;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [BW-1:0]   r_blink, w_blink_nxt;
    logic            r_led, w_led_nxt;
    logic            w_timed, w_timed_nxt, w_entering, w_timeout, w_fail_hit, w_restart;
    logic            w_pin_match, w_puk_match;

    assign w_timed     = (r_state == S_ENT_PIN) || (r_state == S_ENT_OLD) || (r_state == S_ENT_NEW);
    assign w_entering  = w_timed || (r_state == S_ENT_PUK);
    assign w_timeout   = w_timed && (r_timer == TMAX);
    assign w_len       = (r_state == S_ENT_PUK) ? CW'(PUK_LEN) : CW'(PIN_LEN);
    assign w_fail_inc  = r_fail + 1'b1;
    assign w_pin_match = (r_entry[PW-1:0] == r_pin);
    assign w_puk_match = (r_entry == PUK_VALUE);

    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pin      <= PIN_INIT;
            r_fail     <= '0;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
            r_status   <= ST_NONE;
            r_entry    <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_blink    <= '0;
            r_led      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pin      <= w_pin_nxt;
            r_fail     <= w_fail_nxt;
            r_unlocked <= w_unlocked_nxt;
            r_lockout  <= w_lockout_nxt;
            r_status   <= w_status_nxt;
            r_entry    <= w_entry_nxt;
            r_count    <= w_count_nxt;
            r_timer    <= w_timer_nxt;
            r_blink    <= w_blink_nxt;
            r_led      <= w_led_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pin_nxt      = r_pin;
        w_fail_nxt     = r_fail;
        w_unlocked_nxt = r_unlocked;
        w_lockout_nxt  = r_lockout;
        w_status_nxt   = r_status;
        w_entry_nxt    = r_entry;
        w_count_nxt    = r_count;
        w_fail_hit     = 1'b0;
        if (i_clear) begin
            w_entry_nxt  = '0;
            w_count_nxt  = '0;
            w_status_nxt = ST_NONE;
            case (r_state)
                S_IDLE: begin
                    w_state_nxt    = i_mode ? S_ENT_OLD : S_ENT_PIN;
                    w_unlocked_nxt = 1'b0;
                end
                S_LOCKED:  w_state_nxt = S_ENT_PUK;
                S_ENT_NEW: w_state_nxt = S_ENT_OLD;
                default: ;
            endcase
        end else if (w_timeout) begin
            w_fail_hit   = 1'b1;
            w_status_nxt = ST_TOUT;
        end else if (i_enter && w_entering) begin
            if (r_count < w_len) begin
                // unentered digits are zero, so OR-ing places the digit
                if (i_digit <= 4'd9) begin
                    w_entry_nxt = r_entry | (EW'(i_digit) << (4*r_count));
                    w_count_nxt = r_count + 1'b1;
                end
            end else begin
                case (r_state)
                    S_ENT_PIN: begin
                        if (w_pin_match) begin
                            w_unlocked_nxt = 1'b1;
                            w_status_nxt   = ST_ON;
                            w_fail_nxt     = '0;
                            w_state_nxt    = S_IDLE;
                        end else begin
                            w_fail_hit   = 1'b1;
                            w_status_nxt = ST_ERR;
                        end
                    end
                    S_ENT_OLD: begin
                        if (w_pin_match) begin
                            w_status_nxt = ST_OLD_OK;
                            w_state_nxt  = S_ENT_NEW;
                            w_entry_nxt  = '0;
                            w_count_nxt  = '0;
                        end else begin
                            w_fail_hit   = 1'b1;
                            w_status_nxt = ST_ERR;
                        end
                    end
                    S_ENT_NEW: begin
                        w_pin_nxt    = r_entry[PW-1:0];
                        w_status_nxt = ST_STORED;
                        w_fail_nxt   = '0;
                        w_state_nxt  = S_IDLE;
                    end
                    S_ENT_PUK: begin
                        if (w_puk_match) begin
                            w_lockout_nxt = 1'b0;
                            w_fail_nxt    = '0;
                            w_status_nxt  = ST_ON;
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_status_nxt = ST_ERR;
                            w_count_nxt  = '0;
                            w_entry_nxt  = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        // lockout overrides the ERR/TOUT status of the failing attempt
        if (w_fail_hit) begin
            if (w_fail_inc == FMAX) begin
                w_state_nxt   = S_LOCKED;
                w_lockout_nxt = 1'b1;
                w_status_nxt  = ST_LOCK;
                w_fail_nxt    = '0;
            end else begin
                w_fail_nxt  = w_fail_inc;
                w_state_nxt = S_IDLE;
            end
        end

        w_timed_nxt = (w_state_nxt == S_ENT_PIN) || (w_state_nxt == S_ENT_OLD) ||
                      (w_state_nxt == S_ENT_NEW);
        w_restart   = i_clear || (w_state_nxt != r_state);
        if (!w_timed_nxt || w_restart) begin
            w_timer_nxt = '0;
            w_blink_nxt = '0;
            w_led_nxt   = 1'b0;
        end else begin
            w_timer_nxt = r_timer + 1'b1;
            if (r_blink == BMAX) begin
                w_blink_nxt = '0;
                w_led_nxt   = ~r_led;
            end else begin
                w_blink_nxt = r_blink + 1'b1;
                w_led_nxt   = r_led;
            end
        end
    end

    always_comb begin
        o_unlocked  = r_unlocked;
        o_lockout   = r_lockout;
        o_status    = r_status;
        o_entry     = r_entry;
        o_count     = r_count;
        o_timer_led = r_led & w_timed;
    end

endmodule
